// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//
// Holds the architectural PC of the single-issue MIPS core and sequences
// instruction fetches. Each instruction is fetched with a request/ready
// handshake, held for decode until it is consumed (stall low), and the PC
// then advances to the sequential, branch, j/jal or jr target.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          synchronous, active-high
//   stall          decode cannot accept; hold the current instruction
//   branch_taken   current instruction is a taken branch
//   branch_target  word address from the branch adder
//   jump           current instruction is j/jal
//   jump_index     instr[25:0] of j/jal
//   jr             current instruction is jr/jalr
//   jr_addr        register byte address for jr
//   imem_req       fetch request to instruction memory
//   imem_addr      word address, pc[IMEM_ADDR_W+1:2]
//   imem_ready     imem_rdata valid; completes the request
//   imem_rdata     fetched instruction word
//   instr          held instruction for decode
//   instr_valid    instr is valid
//   pc             byte address of instr
//   pc_plus_4      pc + 4 (wraps), registered with pc
//   addr_err       pulses during a consume cycle that selects a misaligned jr
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 14
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  input  logic                   jump,
  input  logic [25:0]            jump_index,
  input  logic                   jr,
  input  logic [31:0]            jr_addr,
  output logic                   imem_req,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic                   imem_ready,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            instr,
  output logic                   instr_valid,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus_4,
  output logic                   addr_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  // The PC is always word aligned, even if the parameter is not.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic [31:0] pc_reg;
  logic [31:0] pc_plus_4_reg;
  logic [31:0] instr_reg;
  logic [31:0] next_pc;
  logic        consume;

  // The branch adder produces a full 32-bit word address; only the low 30
  // bits map into the byte-address space, so the top two are dropped.
  logic unused_branch_bits;
  assign unused_branch_bits = ^branch_target[31:30];

  // The held instruction is taken by decode on any S_VALID edge without stall.
  assign consume = (state_reg == S_VALID) && !stall;

  // Redirect priority: jr, then j/jal, then taken branch, then sequential.
  always_comb begin
    next_pc = pc_plus_4_reg;
    if (jr) begin
      next_pc = {jr_addr[31:2], 2'b00};
    end else if (jump) begin
      next_pc = {pc_plus_4_reg[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = {branch_target[29:0], 2'b00};
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (imem_ready) state_next = S_VALID;
      S_VALID: if (!stall) state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      pc_reg        <= RESET_PC_ALIGNED;
      pc_plus_4_reg <= RESET_PC_ALIGNED + 32'd4;
      instr_reg     <= 32'd0;
    end else begin
      state_reg <= state_next;
      // Capture only while a request is outstanding; ready elsewhere is noise.
      if (state_reg == S_FETCH && imem_ready) begin
        instr_reg <= imem_rdata;
      end
      if (consume) begin
        pc_reg        <= next_pc;
        pc_plus_4_reg <= next_pc + 32'd4;
      end
    end
  end

  assign imem_req    = (state_reg == S_FETCH);
  assign imem_addr   = pc_reg[IMEM_ADDR_W+1:2];
  assign instr       = instr_reg;
  assign instr_valid = (state_reg == S_VALID);
  assign pc          = pc_reg;
  assign pc_plus_4   = pc_plus_4_reg;

  // Flag stays low while reset is held so it reads as its reset value.
  assign addr_err = consume && jr && (jr_addr[1:0] != 2'b00) && !reset;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Testbench for pc_fetch_sequencer: table of per-instruction vectors
// (redirects, memory wait, stall length, expected next PC), a queue of
// expected fetch PCs filled at each consume, plus reset corner sequences.
module tb_pc_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_addr;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        addr_err;
  logic        force_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        jr;
    logic [31:0] jr_addr;
    logic        jump;
    logic [25:0] jidx;
    logic        br;
    logic [31:0] btgt;
    int          wait_c;
    int          stall_c;
    logic        err;
    logic [31:0] nxt;
  } vec_t;

  vec_t vecs[15];

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return {a, 4'hC, a};
  endfunction

  assign imem_rdata = force_rdata ? 32'hDEAD_BEEF : mem_word(imem_addr);

  pc_fetch_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .IMEM_ADDR_W (14)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_addr       (jr_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus_4     (pc_plus_4),
    .addr_err      (addr_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_redirects();
    jr = 1'b0; jr_addr = 32'h0; jump = 1'b0; jump_index = 26'h0;
    branch_taken = 1'b0; branch_target = 32'h0;
  endtask

  // Entered in S_FETCH at one cycle past an edge; leaves in S_FETCH likewise.
  task automatic run_vec(input vec_t v);
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      exp_pc = exp_q.pop_front();
    end
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(exp_pc[15:2]));
    imem_ready = 1'b0;
    for (int i = 0; i < v.wait_c; i++) begin
      tick();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", 32'(imem_addr), 32'(exp_pc[15:2]));
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end
    imem_ready = 1'b1;
    tick();
    chk("valid", 32'(instr_valid), 32'd1);
    chk("valid_req", 32'(imem_req), 32'd0);
    chk("pc", pc, exp_pc);
    chk("pc_plus_4", pc_plus_4, exp_pc + 32'd4);
    chk("instr", instr, mem_word(exp_pc[15:2]));
    // Stalled cycles carry junk redirects that must be ignored.
    if (v.stall_c > 0) begin
      stall = 1'b1; jr = 1'b1; jr_addr = 32'h0000_0003; jump = 1'b1; branch_taken = 1'b1;
      for (int i = 0; i < v.stall_c; i++) begin
        tick();
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_req", 32'(imem_req), 32'd0);
        chk("stall_pc", pc, exp_pc);
        chk("stall_instr", instr, mem_word(exp_pc[15:2]));
        chk("stall_addr_err", 32'(addr_err), 32'd0);
      end
    end
    stall = 1'b0;
    jr = v.jr; jr_addr = v.jr_addr; jump = v.jump; jump_index = v.jidx;
    branch_taken = v.br; branch_target = v.btgt;
    #1;
    chk("addr_err", 32'(addr_err), 32'(v.err));
    exp_q.push_back(v.nxt);
    tick();
    chk("addr_err_pulse", 32'(addr_err), 32'd0);
    chk("next_req", 32'(imem_req), 32'd1);
    chk("next_addr", 32'(imem_addr), 32'(v.nxt[15:2]));
    clear_redirects();
    $display("[TB] consume pc=%h wait=%0d stall=%0d -> next pc %h", exp_pc, v.wait_c, v.stall_c, v.nxt);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    //         jr    jr_addr        jump  jidx           br    btgt           w  s  err   next
    vecs[0]  = '{1'b0, 32'h0,         1'b0, 26'h0,         1'b0, 32'h0,         0, 0, 1'b0, 32'h0000_0004};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 26'h0,         1'b0, 32'h0,         1, 0, 1'b0, 32'h0000_0008};
    vecs[2]  = '{1'b1, 32'h0000_0040, 1'b0, 26'h0,         1'b0, 32'h0,         0, 0, 1'b0, 32'h0000_0040};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 26'h0,         1'b1, 32'h0000_0008, 0, 0, 1'b0, 32'h0000_0020};
    vecs[4]  = '{1'b1, 32'h1000_0010, 1'b0, 26'h0,         1'b0, 32'h0,         0, 0, 1'b0, 32'h1000_0010};
    vecs[5]  = '{1'b0, 32'h0,         1'b1, 26'h000_0100,  1'b0, 32'h0,         0, 0, 1'b0, 32'h1000_0400};
    vecs[6]  = '{1'b1, 32'h1000_0010, 1'b0, 26'h0,         1'b0, 32'h0,         0, 0, 1'b0, 32'h1000_0010};
    vecs[7]  = '{1'b1, 32'h0000_0084, 1'b1, 26'h3FF_FFFF,  1'b1, 32'h0000_0123, 0, 0, 1'b0, 32'h0000_0084};
    vecs[8]  = '{1'b1, 32'h0000_0087, 1'b0, 26'h0,         1'b0, 32'h0,         3, 4, 1'b1, 32'h0000_0084};
    vecs[9]  = '{1'b0, 32'h0,         1'b0, 26'h0,         1'b1, 32'hC000_0005, 0, 0, 1'b0, 32'h0000_0014};
    vecs[10] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0,         1'b0, 32'h0,         0, 0, 1'b0, 32'hFFFF_FFFC};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 26'h0,         1'b0, 32'h0,         0, 0, 1'b0, 32'h0000_0000};
    vecs[12] = '{1'b0, 32'h0,         1'b1, 26'h000_0003,  1'b0, 32'h0,         0, 2, 1'b0, 32'h0000_000C};
    vecs[13] = '{1'b0, 32'h0,         1'b1, 26'h000_0010,  1'b1, 32'h0000_0099, 0, 0, 1'b0, 32'h0000_0040};
    vecs[14] = '{1'b0, 32'h0,         1'b0, 26'h0,         1'b0, 32'h0,         2, 1, 1'b0, 32'h0000_0044};

    reset = 1'b1; stall = 1'b0; imem_ready = 1'b1; force_rdata = 1'b0;
    clear_redirects();
    tick();
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus_4", pc_plus_4, 32'h4);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    exp_q.push_back(32'h0);
    tick();

    for (int k = 0; k < 15; k++) begin
      run_vec(vecs[k]);
    end

    // Reset while a fetch waits, with late ready/data around the reset edge.
    imem_ready = 1'b0;
    tick();
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    reset = 1'b1; imem_ready = 1'b1; force_rdata = 1'b1;
    tick();
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_pc_plus_4", pc_plus_4, 32'h4);
    reset = 1'b0;
    #1;
    chk("midrst_idle_req", 32'(imem_req), 32'd0);
    tick();
    chk("midrst_idle_instr", instr, 32'h0);
    chk("midrst_refetch_req", 32'(imem_req), 32'd1);
    chk("midrst_refetch_addr", 32'(imem_addr), 32'h0);
    force_rdata = 1'b0;
    tick();
    chk("midrst_refetch_valid", 32'(instr_valid), 32'd1);
    chk("midrst_refetch_instr", instr, mem_word(14'h0));
    chk("midrst_refetch_pc", pc, 32'h0);
    $display("[TB] reset mid-fetch: refetched pc=%h instr=%h", 32'h0, mem_word(14'h0));
    exp_q.delete();

    // Reset while stalled in S_VALID.
    stall = 1'b1;
    tick();
    chk("stallrst_pre_valid", 32'(instr_valid), 32'd1);
    reset = 1'b1;
    tick();
    chk("stallrst_valid", 32'(instr_valid), 32'd0);
    chk("stallrst_instr", instr, 32'h0);
    reset = 1'b0; stall = 1'b0;
    tick();
    chk("stallrst_fetch_addr", 32'(imem_addr), 32'h0);
    $display("[TB] reset while stalled: instr_valid dropped");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
